stream_mux_rr: RTL and testbench

Registered N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output. Selects one source per cycle either by an explicit select (fixed mode, the generalised 2:1 mux behaviour) or by fair round-robin arbitration (RR mode), and holds the chosen word in a single output register until the consumer takes it. Sits between multiple producers and one shared downstream datapath.

---
 rtl/stream_mux_rr.sv | 109 ++++++++++
 tb/tb_stream_mux_rr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// Purpose : N-channel valid/ready stream mux, fixed-select or round-robin, registered output.
// Latency : one cycle from input handshake to out_valid/out_data.
// Backpressure: out_ready=0 with a held word forces every in_ready low in the same cycle.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   mode, sel         0 = take channel sel, 1 = round-robin over valid channels
//   in_data/valid     N packed channels (channel i at [i*WIDTH +: WIDTH]), per-channel valid
//   in_ready          per-channel ready, combinational, at most one bit set
//   out_data/chan     registered word and the index of the channel it came from
//   out_valid/ready   output handshake
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [SELW:0] NUM_CH = (SELW+1)'(N);

  logic [SELW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_chan;
  logic             r_out_valid;

  logic             w_load;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gnt_data;
  logic [SELW-1:0]  w_ptr_nxt;

  // Output register can take a word when empty or being drained this cycle.
  assign w_load = ~r_out_valid | out_ready;

  // Grant selection. In RR mode the search starts at r_ptr and wraps, the
  // first valid channel found wins; later hits are ignored via w_gnt_vld.
  always_comb begin : grant_sel
    logic [SELW-1:0] v_idx;
    v_idx     = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (!mode) begin
      // Out-of-range select never grants.
      if (({1'b0, sel} < NUM_CH) && in_valid[sel]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = sel;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        v_idx = SELW'((int'(r_ptr) + k) % N);
        if (!w_gnt_vld && in_valid[v_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = v_idx;
        end
      end
    end
  end

  // Grant implies in_valid, so a grant that can load is a transfer.
  assign w_xfer     = w_load & ~rst & w_gnt_vld;
  assign w_gnt_data = in_data[w_gnt_idx*WIDTH +: WIDTH];
  assign w_ptr_nxt  = SELW'((int'(w_gnt_idx) + 1) % N);

  always_comb begin
    in_ready = '0;
    if (w_xfer) begin
      in_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_chan  <= w_gnt_idx;
        // Pointer advances past the winner only for round-robin transfers.
        if (mode) begin
          r_ptr <= w_ptr_nxt;
        end
      end else begin
        // Nothing to refill with: a drained word is not replaced.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                mode;
  logic [SELW-1:0]     sel;
  logic [N*WIDTH-1:0]  in_data;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_ready;
  logic [WIDTH-1:0]    out_data;
  logic [SELW-1:0]     out_chan;
  logic                out_valid;
  logic                out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        ordy;
    logic [31:0] data;
    logic [3:0]  erdy;   // expected in_ready during the cycle
    logic        eov;    // expected outputs after the edge
    logic [1:0]  eoc;
    logic [7:0]  eod;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic m, input logic [1:0] s, input logic [3:0] v,
                     input logic o, input logic [31:0] d, input logic [3:0] er,
                     input logic eov, input logic [1:0] eoc, input logic [7:0] eod);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.vld = v; t.ordy = o; t.data = d;
    t.erdy = er; t.eov = eov; t.eoc = eoc; t.eod = eod;
    vecs.push_back(t);
  endtask

  // Reference model state
  logic       m_ov;
  logic [7:0] m_od;
  logic [1:0] m_oc;
  int         m_ptr;

  // Grant from the rules: fixed -> sel if valid; RR -> valid channel at the
  // smallest forward distance from the pointer.
  task automatic model_grant(output logic gv, output int g);
    int best;
    gv = 1'b0;
    g = 0;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) begin
        gv = 1'b1;
        g = int'(sel);
      end
    end else begin
      best = N;
      for (int c = 0; c < N; c++) begin
        if (in_valid[c] && ((c - m_ptr + N) % N) < best) begin
          best = (c - m_ptr + N) % N;
          g = c;
          gv = 1'b1;
        end
      end
    end
  endtask

  localparam logic [31:0] D_RR = 32'h13121110;
  localparam logic [31:0] D_FX = 32'h13A51110;
  localparam logic [31:0] D_BP = 32'h13331110;

  initial begin
    logic       gv;
    int         g;
    logic       ld;
    logic [3:0] erdy;

    rst = 1'b1; mode = 1'b1; sel = '0; in_data = D_RR; in_valid = 4'hF; out_ready = 1'b1;

    // Reset held 3 cycles with all channels valid
    for (int i = 0; i < 3; i++) add(1, 1, 0, 4'hF, 1, D_RR, 4'h0, 0, 0, 8'h00);
    // RR, all valid: 0,1,2,3,0,1,2,3 back to back
    for (int i = 0; i < 8; i++)
      add(0, 1, 0, 4'hF, 1, D_RR, 4'(1 << (i % 4)), 1, 2'(i % 4), 8'(8'h10 + i % 4));
    // Fixed select ch2, then sel=3 with ch3 idle -> no grant, output drains
    add(0, 0, 2, 4'hF, 1, D_FX, 4'b0100, 1, 2, 8'hA5);
    add(0, 0, 3, 4'b0111, 1, D_FX, 4'b0000, 0, 0, 8'h00);
    // Move ptr to 3 by granting ch2 alone (fixed mode left ptr at 0)
    add(0, 1, 0, 4'b0100, 1, D_RR, 4'b0100, 1, 2, 8'h12);
    // Skip and wrap: ch0, ch2, ch0 -> ptr 1, confirmed by next grant ch1
    add(0, 1, 0, 4'b0101, 1, D_RR, 4'b0001, 1, 0, 8'h10);
    add(0, 1, 0, 4'b0101, 1, D_RR, 4'b0100, 1, 2, 8'h12);
    add(0, 1, 0, 4'b0101, 1, D_RR, 4'b0001, 1, 0, 8'h10);
    add(0, 1, 0, 4'hF, 1, D_RR, 4'b0010, 1, 1, 8'h11);
    // Backpressure: load 8'h33 from ch2 (ptr->3), stall 5 cycles, then drain+refill ch3
    add(0, 1, 0, 4'hF, 1, D_BP, 4'b0100, 1, 2, 8'h33);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 4'hF, 0, D_BP, 4'b0000, 1, 2, 8'h33);
    add(0, 1, 0, 4'hF, 1, D_BP, 4'b1000, 1, 3, 8'h13);
    // Reset with a held word and a stalled consumer, then first grant is ch0
    add(1, 1, 0, 4'hF, 0, D_RR, 4'b0000, 0, 0, 8'h00);
    add(0, 1, 0, 4'hF, 0, D_RR, 4'b0001, 1, 0, 8'h10);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; mode = vecs[i].mode; sel = vecs[i].sel;
      in_valid = vecs[i].vld; out_ready = vecs[i].ordy; in_data = vecs[i].data;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].erdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
      if (vecs[i].eov || vecs[i].rst) begin
        chk($sformatf("vec%0d out_chan", i), 32'(out_chan), 32'(vecs[i].eoc));
        chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].eod));
      end
    end

    // Randomized run against the model; first cycle is a reset to sync state.
    m_ov = 1'b0; m_od = '0; m_oc = '0; m_ptr = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst       = (n == 0) || ($urandom_range(0, 40) == 0);
      mode      = 1'($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      #1;
      model_grant(gv, g);
      ld = ~m_ov | out_ready;
      erdy = (ld && !rst && gv) ? 4'(1 << g) : 4'h0;
      chk("rand in_ready", 32'(in_ready), 32'(erdy));
      @(posedge clk);
      if (rst) begin
        m_ov = 1'b0; m_od = '0; m_oc = '0; m_ptr = 0;
      end else if (ld) begin
        if (gv) begin
          m_ov = 1'b1;
          m_od = in_data[g*8 +: 8];
          m_oc = 2'(g);
          if (mode) m_ptr = (g + 1) % N;
        end else begin
          m_ov = 1'b0;
        end
      end
      #1;
      chk("rand out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("rand out_chan", 32'(out_chan), 32'(m_oc));
        chk("rand out_data", 32'(out_data), 32'(m_od));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
